// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the contact-bounce emulator.
// The optional abort input is enabled by defining BOUNCE_GEN_ABORT_EN;
// nothing in this package depends on it.
package bounce_gen_pkg;

    // Sequencer states of the bounce generator.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } bg_state_t;

    // Galois feedback taps for the 16-bit pseudo-random source.
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // Seed substituted whenever an all-zero seed is requested (the
    // all-zero state is a lock-up state for an XOR LFSR).
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // One right-shift step of the Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] shifted;
        shifted = {1'b0, cur[15:1]};
        if (cur[0]) begin
            lfsr_next = shifted ^ LFSR_MASK;
        end else begin
            lfsr_next = shifted;
        end
    endfunction

    // Replace the illegal all-zero seed by the default one.
    function automatic logic [15:0] lfsr_seed_fix(input logic [15:0] seed);
        if (seed == 16'h0000) begin
            lfsr_seed_fix = LFSR_DEFAULT_SEED;
        end else begin
            lfsr_seed_fix = seed;
        end
    endfunction

endpackage : bounce_gen_pkg

// File: rtl/bounce_generator_lfsr16.sv
// Free-running 16-bit Galois LFSR used as the gap randomiser.
// It advances on every clock edge out of reset, independent of what the
// bounce sequencer is doing, so gap lengths depend on when a request lands.
module lfsr16
    import bounce_gen_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clock,
    input  logic        resetn,
    output logic [15:0] q
);

    localparam logic [15:0] SEED_EFF = lfsr_seed_fix(SEED);

    // LFSR register: loads the seed on reset, steps every cycle otherwise.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q <= SEED_EFF;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule : lfsr16

// File: rtl/bounce_generator.sv
// Contact-bounce emulator. On a request it moves bounced_o to the requested
// level through a burst of 2*BOUNCES+1 toggles separated by pseudo-random
// gaps of 1..2**GAP_W cycles, holds the level for SETTLE_CYCLES cycles and
// then reports completion.
//
// Optional feature: define BOUNCE_GEN_ABORT_EN to add the abort_i input,
// which forces bounced_o to the target and finishes the transition early.
//
// Request/complete handshake:
//   start_i/target_i are sampled only in IDLE while done_o is low; an accepted
//   request raises busy_o from the next cycle. busy_o stays high until the
//   cycle in which done_o pulses (busy_o is low in that cycle). Requests seen
//   while busy_o or done_o is high are dropped, never queued, so the earliest
//   new acceptance is the edge that ends the cycle after done_o.
//
// Timing of the completion: the FSM spends SETTLE_CYCLES cycles in SETTLE,
// one cycle in DONE, and done_o is the registered image of the DONE state, so
// the pulse appears in the cycle after DONE. A request whose target already
// equals bounced_o therefore completes SETTLE_CYCLES+2 cycles after the cycle
// in which start_i was presented.
module bounce_generator
    import bounce_gen_pkg::*;
#(
    parameter int          BOUNCES       = 3,
    parameter int          GAP_W         = 3,
    parameter int          SETTLE_CYCLES = 32,
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter logic        INIT_LEVEL    = 1'b0
) (
    input  logic      clock,
    input  logic      resetn,
    input  logic      start_i,
    input  logic      target_i,
`ifdef BOUNCE_GEN_ABORT_EN
    input  logic      abort_i,
`endif
    output logic      bounced_o,
    output logic      busy_o,
    output logic      done_o,
    output bg_state_t state_dbg
);

    // Total toggles per transition; odd, so the last one lands on the target.
    localparam int TOGGLES = 2 * BOUNCES + 1;
    localparam int TOG_W   = $clog2(2 * BOUNCES + 2);
    localparam int GAP_CW  = GAP_W + 1;
    localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);

    localparam logic [TOG_W-1:0]  TOG_LAST = TOG_W'(TOGGLES);
    localparam logic [TOG_W-1:0]  TOG_ONE  = TOG_W'(1);
    localparam logic [GAP_CW-1:0] GAP_ONE  = GAP_CW'(1);
    localparam logic [SET_W-1:0]  SET_LOAD = SET_W'(SETTLE_CYCLES);
    localparam logic [SET_W-1:0]  SET_ONE  = SET_W'(1);

    bg_state_t         state;
    logic              target_q;
    logic [TOG_W-1:0]  toggle_cnt;
    logic [GAP_CW-1:0] gap_cnt;
    logic [SET_W-1:0]  settle_cnt;

    logic [15:0]       lfsr_q;
    logic [GAP_CW-1:0] gap_load;
    logic              abort_req;
    logic              unused_lfsr_bits;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clock  (clock),
        .resetn (resetn),
        .q      (lfsr_q)
    );

    // Next gap length: 1 + low LFSR bits, i.e. 1..2**GAP_W cycles.
    assign gap_load = {1'b0, lfsr_q[GAP_W-1:0]} + GAP_ONE;

    // Only the low GAP_W bits of the LFSR shape the gaps.
    assign unused_lfsr_bits = ^lfsr_q[15:GAP_W];

`ifdef BOUNCE_GEN_ABORT_EN
    assign abort_req = abort_i;
`else
    assign abort_req = 1'b0;
`endif

    assign state_dbg = state;

    // Sequencer: state, gap/settle/toggle counters and all registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            target_q   <= INIT_LEVEL;
            toggle_cnt <= '0;
            gap_cnt    <= '0;
            settle_cnt <= '0;
            bounced_o  <= INIT_LEVEL;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            // done_o pulses in the cycle following the single DONE cycle.
            done_o <= (state == DONE);

            case (state)
                IDLE: begin
                    busy_o <= 1'b0;
                    // A request during the done_o cycle is deliberately dropped.
                    if (start_i && !done_o) begin
                        target_q <= target_i;
                        busy_o   <= 1'b1;
                        if (target_i != bounced_o) begin
                            // First toggle happens right away; the rest follow in BOUNCE.
                            bounced_o  <= ~bounced_o;
                            toggle_cnt <= TOG_ONE;
                            gap_cnt    <= gap_load;
                            state      <= BOUNCE;
                        end else begin
                            // Already at the target: no toggles, just the settle hold.
                            settle_cnt <= SET_LOAD;
                            state      <= SETTLE;
                        end
                    end
                end

                BOUNCE: begin
                    if (abort_req) begin
                        bounced_o  <= target_q;
                        toggle_cnt <= '0;
                        gap_cnt    <= '0;
                        state      <= DONE;
                    end else if (gap_cnt == GAP_ONE) begin
                        if (toggle_cnt == TOG_LAST) begin
                            // Last toggle has had its full gap; start the stable hold.
                            toggle_cnt <= '0;
                            gap_cnt    <= '0;
                            settle_cnt <= SET_LOAD;
                            state      <= SETTLE;
                        end else begin
                            bounced_o  <= ~bounced_o;
                            toggle_cnt <= toggle_cnt + TOG_ONE;
                            gap_cnt    <= gap_load;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end

                SETTLE: begin
                    // By parity bounced_o already equals the target; hold it there.
                    bounced_o <= target_q;
                    if (abort_req) begin
                        settle_cnt <= '0;
                        state      <= DONE;
                    end else if (settle_cnt == SET_ONE) begin
                        settle_cnt <= '0;
                        state      <= DONE;
                    end else begin
                        settle_cnt <= settle_cnt - SET_ONE;
                    end
                end

                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule : bounce_generator

// File: tb/tb_bounce_generator.sv
// Bench for bounce_generator with default parameters (BOUNCES=3, GAP_W=3,
// SETTLE_CYCLES=32, SEED=16'hACE1, INIT_LEVEL=0). Define BOUNCE_GEN_ABORT_EN
// to build the abort variant.
`timescale 1ns/1ps
module tb_bounce_generator;
    import bounce_gen_pkg::*;

    localparam int          N_TOG   = 7;    // 2*BOUNCES+1
    localparam int          SET     = 32;   // SETTLE_CYCLES
    localparam int          MAX_GAP = 8;    // 2**GAP_W
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          SB_W    = 5;    // {level, edges[3:0]}
    localparam int          LIMIT   = 250;

    // ---------------- clock / reset ----------------
    logic      clock = 1'b0;
    logic      resetn = 1'b0;
    logic      start_i = 1'b0;
    logic      target_i = 1'b0;
`ifdef BOUNCE_GEN_ABORT_EN
    logic      abort_i = 1'b0;
`endif
    logic      bounced_o;
    logic      busy_o;
    logic      done_o;
    bg_state_t state_dbg;

    always #5 clock = ~clock;

    bounce_generator dut (
        .clock     (clock),
        .resetn    (resetn),
        .start_i   (start_i),
        .target_i  (target_i),
`ifdef BOUNCE_GEN_ABORT_EN
        .abort_i   (abort_i),
`endif
        .bounced_o (bounced_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int              n_cmp = 0;
    int              n_bad = 0;
    logic [SB_W-1:0] exp_q[$];
    logic [SB_W-1:0] ent;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference LFSR: value the DUT used at the most recent rising edge.
    logic [15:0] lfsr_m    = SEED;
    logic [15:0] lfsr_used = SEED;
    always @(posedge clock) begin
        lfsr_used = lfsr_m;
        if (resetn) lfsr_m = lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
    end
    always @(negedge resetn) lfsr_m = SEED;

    // Loopback debouncer (N=5): output follows input after 5 stable cycles.
    logic deb = 1'b0;
    int   deb_cnt = 0;
    always @(posedge clock) begin
        if (!resetn) begin
            deb = 1'b0;
            deb_cnt = 0;
        end else if (bounced_o == deb) begin
            deb_cnt = 0;
        end else begin
            deb_cnt++;
            if (deb_cnt >= 5) begin
                deb = bounced_o;
                deb_cnt = 0;
            end
        end
    end

    // ---------------- monitor (samples on falling edge) ----------------
    int   cyc = 0;
    logic prev_b = 1'b0;
    logic prev_busy = 1'b0;
    logic in_txn = 1'b0;
    int   edges = 0;
    int   last_tog = 0;
    int   exp_gap = 0;
    int   exp_done = -1;
    int   done_seen = 0;
    logic abort_mode = 1'b0;

    always @(negedge clock) begin
        cyc++;
        if (!resetn) begin
            in_txn = 1'b0;
            edges = 0;
            exp_done = -1;
        end else begin
            if (busy_o && !prev_busy && !in_txn) begin
                in_txn = 1'b1;
                edges = 0;
                if (bounced_o == prev_b) exp_done = cyc + SET + 1;
            end
            if (bounced_o != prev_b) begin
                if (!in_txn) begin
                    check("idle_edge", 1, 0);
                end else begin
                    edges++;
                    if (edges > 1) begin
                        check("gap_len", cyc - last_tog, exp_gap);
                        check("gap_range", int'((cyc - last_tog) >= 1 && (cyc - last_tog) <= MAX_GAP), 1);
                    end
                    last_tog = cyc;
                    exp_gap = 1 + int'(lfsr_used[2:0]);
                    if (edges == N_TOG) exp_done = cyc + exp_gap + SET + 1;
                end
            end
            if (in_txn && !busy_o && !done_o) check("busy_held", 0, 1);
            if (done_o) begin
                done_seen++;
                check("done_busy_low", busy_o, 0);
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    ent = exp_q.pop_front();
                    check("final_level", bounced_o, ent[4]);
                    check("edge_count", edges, ent[3:0]);
                    if (!abort_mode) begin
                        check("done_time", cyc, exp_done);
                        check("debounced", deb, ent[4]);
                    end
                end
                in_txn = 1'b0;
            end
        end
        prev_b = bounced_o;
        prev_busy = busy_o;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n = 0;
        while ((busy_o || done_o) && n < LIMIT) begin
            @(posedge clock); #1;
            n++;
        end
        check("wait_idle", int'(n < LIMIT), 1);
    endtask

    task automatic issue(input logic tgt, input int exp_edges);
        wait_idle();
        exp_q.push_back({tgt, 4'(exp_edges)});
        start_i = 1'b1;
        target_i = tgt;
        @(posedge clock); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0 = done_seen;
        int n = 0;
        while (done_seen == d0 && n < LIMIT) begin
            @(posedge clock); #1;
            n++;
        end
        check(name, int'(done_seen != d0), 1);
    endtask

    task automatic wait_edges(input int k);
        int n = 0;
        while (edges < k && n < LIMIT) begin
            @(negedge clock); #1;
            n++;
        end
        check("wait_edges", int'(n < LIMIT), 1);
    endtask

    // Directed vectors {target, expected edge count}; level starts at 0.
    logic [SB_W-1:0] vec [5] = '{5'b1_0111, 5'b1_0000, 5'b0_0111, 5'b0_0000, 5'b1_0111};

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset held, outputs at reset values.
        repeat (10) @(posedge clock);
        #1;
        check("rst_bounced", bounced_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_state", int'(state_dbg), int'(IDLE));
        resetn = 1'b1;
        repeat (100) @(posedge clock);
        #1;
        check("idle_bounced", bounced_o, 0);
        check("idle_busy", busy_o, 0);

        // Bouncing and same-level transitions.
        for (int i = 0; i < 5; i++) begin
            issue(vec[i][4], int'(vec[i][3:0]));
            wait_done("vec_done");
        end

        // Requests while busy are dropped (level 1 -> 0).
        issue(1'b0, 7);
        for (int i = 0; i < 15; i++) begin
            @(posedge clock); #1;
            start_i = 1'b1;
            target_i = 1'b1;
            @(posedge clock); #1;
            start_i = 1'b0;
        end
        wait_done("busy_ignore_done");
        repeat (50) @(posedge clock);
        #1;
        check("no_queued_start", busy_o, 0);
        check("level_after_ignore", bounced_o, 0);

        // Request in the done_o cycle is dropped, next cycle accepted.
        issue(1'b1, 7);
        begin
            int n = 0;
            while (!done_o && n < LIMIT) begin
                @(posedge clock); #1;
                n++;
            end
            check("wait_done_pulse", int'(done_o), 1);
        end
        start_i = 1'b1;
        target_i = 1'b0;
        exp_q.push_back({1'b0, 4'd7});
        @(posedge clock); #1;
        check("start_in_done_ignored", busy_o, 0);
        @(posedge clock); #1;
        check("start_after_done_accepted", busy_o, 1);
        start_i = 1'b0;
        wait_done("after_done_done");

        // Reset in the middle of BOUNCE, then a fresh transition.
        issue(1'b1, 7);
        wait_edges(2);
        #2;
        resetn = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_bounced", bounced_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_done", done_o, 0);
        repeat (3) @(posedge clock);
        #1;
        resetn = 1'b1;
        issue(1'b1, 7);
        wait_done("fresh_done");

`ifdef BOUNCE_GEN_ABORT_EN
        // Abort after the third edge (level 1 -> 0).
        abort_mode = 1'b1;
        issue(1'b0, 3);
        wait_edges(3);
        abort_i = 1'b1;
        @(posedge clock); #1;
        abort_i = 1'b0;
        check("abort_level", bounced_o, 0);
        check("abort_no_done_yet", done_o, 0);
        @(posedge clock); #1;
        check("abort_done", done_o, 1);
        @(negedge clock); #1;
        abort_mode = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check("abort_debounced", deb, 0);

        // Abort during SETTLE of a same-level request.
        abort_mode = 1'b1;
        issue(1'b0, 0);
        repeat (5) @(posedge clock);
        #1;
        abort_i = 1'b1;
        @(posedge clock); #1;
        abort_i = 1'b0;
        check("settle_abort_level", bounced_o, 0);
        @(posedge clock); #1;
        check("settle_abort_done", done_o, 1);
        @(negedge clock); #1;
        abort_mode = 1'b0;
`endif

        wait_idle();
        repeat (5) @(posedge clock);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_bounce_generator
